// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite responder exposing four read/write registers in a 16-byte window.
// Independent write and read FSMs; synchronous active-high reset.
module axi_lite_reg_slave #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    RESP_WIDTH = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'h00
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [RESP_WIDTH-1:0]   s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(2'd0);
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2'd2);
  localparam logic [RESP_WIDTH-1:0] RESP_DECERR = RESP_WIDTH'(2'd3);

  typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  function automatic logic [RESP_WIDTH-1:0] decode_resp(input logic [ADDR_WIDTH-1:0] addr);
    logic [RESP_WIDTH-1:0] resp;
    if (addr[ADDR_WIDTH-1:4] != BASE_ADDR[ADDR_WIDTH-1:4]) resp = RESP_DECERR;
    else if (addr[1:0] != 2'd0)                            resp = RESP_SLVERR;
    else                                                   resp = RESP_OKAY;
    return resp;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_val,
                                                        input logic [DATA_WIDTH-1:0] new_val,
                                                        input logic [NBYTES-1:0]     strb);
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int i = 0; i < NBYTES; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  w_state_e              w_state_r;
  r_state_e              r_state_r;
  logic [DATA_WIDTH-1:0] regs_r [4];
  logic [ADDR_WIDTH-1:0] aw_addr_r;
  logic [DATA_WIDTH-1:0] w_data_r;
  logic [NBYTES-1:0]     w_strb_r;
  logic                  bvalid_r;
  logic [RESP_WIDTH-1:0] bresp_r;
  logic                  rvalid_r;
  logic [RESP_WIDTH-1:0] rresp_r;
  logic [DATA_WIDTH-1:0] rdata_r;

  logic                  wr_commit_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic [NBYTES-1:0]     wr_strb_s;
  logic [RESP_WIDTH-1:0] wr_resp_s;
  logic [RESP_WIDTH-1:0] rd_resp_s;
  logic                  wstrb_msb_unused_s;

  // The top strobe bit has no data byte behind it.
  assign wstrb_msb_unused_s = s_axi_wstrb[NBYTES];

  // Readies are decoded from state so they rise in the first cycle out of reset.
  assign s_axi_awready = ~s_axi_areset & ((w_state_r == W_IDLE) | (w_state_r == W_WAIT_ADDR));
  assign s_axi_wready  = ~s_axi_areset & ((w_state_r == W_IDLE) | (w_state_r == W_WAIT_DATA));
  assign s_axi_arready = ~s_axi_areset & (r_state_r == R_IDLE);
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rresp   = rresp_r;
  assign s_axi_rdata   = rdata_r;
  assign rd_resp_s     = decode_resp(s_axi_araddr);

  // Select the address/data pair that completes a write in this cycle.
  always_comb begin
    wr_commit_s = 1'b0;
    wr_addr_s   = s_axi_awaddr;
    wr_data_s   = s_axi_wdata;
    wr_strb_s   = s_axi_wstrb[NBYTES-1:0];
    case (w_state_r)
      W_IDLE:      wr_commit_s = s_axi_awvalid & s_axi_wvalid;
      W_WAIT_DATA: begin
        wr_commit_s = s_axi_wvalid;
        wr_addr_s   = aw_addr_r;
      end
      W_WAIT_ADDR: begin
        wr_commit_s = s_axi_awvalid;
        wr_data_s   = w_data_r;
        wr_strb_s   = w_strb_r;
      end
      default:     wr_commit_s = 1'b0;
    endcase
    wr_resp_s = decode_resp(wr_addr_s);
  end

  // Write FSM, register file and B channel.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state_r <= W_IDLE;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
      aw_addr_r <= '0;
      w_data_r  <= '0;
      w_strb_r  <= '0;
      for (int i = 0; i < 4; i++) regs_r[i] <= '0;
    end else begin
      if (wr_commit_s && (wr_resp_s == RESP_OKAY)) begin
        regs_r[wr_addr_s[3:2]] <= merge_bytes(regs_r[wr_addr_s[3:2]], wr_data_s, wr_strb_s);
      end
      if (wr_commit_s) begin
        w_state_r <= W_RESP;
        bvalid_r  <= 1'b1;
        bresp_r   <= wr_resp_s;
      end else begin
        case (w_state_r)
          W_IDLE: begin
            if (s_axi_awvalid) begin
              aw_addr_r <= s_axi_awaddr;
              w_state_r <= W_WAIT_DATA;
            end else if (s_axi_wvalid) begin
              w_data_r  <= s_axi_wdata;
              w_strb_r  <= s_axi_wstrb[NBYTES-1:0];
              w_state_r <= W_WAIT_ADDR;
            end
          end
          W_WAIT_DATA, W_WAIT_ADDR: w_state_r <= w_state_r;
          W_RESP: begin
            if (s_axi_bready) begin
              bvalid_r  <= 1'b0;
              w_state_r <= W_IDLE;
            end
          end
          default: begin
            bvalid_r  <= 1'b0;
            w_state_r <= W_IDLE;
          end
        endcase
      end
    end
  end

  // Read FSM; samples the register file before any same-edge write lands.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state_r <= R_IDLE;
      rvalid_r  <= 1'b0;
      rresp_r   <= RESP_OKAY;
      rdata_r   <= '0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            rresp_r   <= rd_resp_s;
            rdata_r   <= (rd_resp_s == RESP_OKAY) ? regs_r[s_axi_araddr[3:2]] : '0;
            rvalid_r  <= 1'b1;
            r_state_r <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            rvalid_r  <= 1'b0;
            r_state_r <= R_IDLE;
          end
        end
        default: begin
          rvalid_r  <= 1'b0;
          r_state_r <= R_IDLE;
        end
      endcase
    end
  end

endmodule
